// File: rtl/minesweeper_pkg.sv
// Board geometry, placer state encoding and cell-index helpers
// shared by the minesweeper datapath, ALU and display blocks.
package minesweeper_pkg;

    localparam int BOARD_W = 5;
    localparam int BOARD_H = 5;
    localparam int CELLS   = BOARD_W * BOARD_H;
    localparam int IDX_W   = 5;
    localparam int ADJ_W   = 4;
    localparam int LFSR_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PICK,
        ADJ,
        DONE
    } place_state_e;

    function automatic int idx_row(input logic [IDX_W-1:0] idx);
        return int'(idx) / BOARD_W;
    endfunction

    function automatic int idx_col(input logic [IDX_W-1:0] idx);
        return int'(idx) % BOARD_W;
    endfunction

    function automatic logic in_board(input int row, input int col);
        return (row >= 0) && (row < BOARD_H) &&
               (col >= 0) && (col < BOARD_W);
    endfunction

endpackage

// File: rtl/mine_placer_if.sv
// Command/status and cell read port between the main FSM (master)
// and the mine placer (slave).
interface mine_placer_if;
    import minesweeper_pkg::*;

    logic             start;
    logic             place_done;
    logic             busy;
    logic [CELLS-1:0] mine_map;
    logic [IDX_W-1:0] rd_addr;
    logic             rd_mine;
    logic [ADJ_W-1:0] rd_adj;

    modport master (
        output start, rd_addr,
        input  place_done, busy, mine_map, rd_mine, rd_adj
    );

    modport slave (
        input  start, rd_addr,
        output place_done, busy, mine_map, rd_mine, rd_adj
    );

endinterface

// File: rtl/mine_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, period 255.
// A zero seed would lock up, so it is replaced by 1.
module mine_lfsr
    import minesweeper_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              step_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clka) begin
        if (!restart_n) lfsr_q <= SEED_EFF;
        else            lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mine_placer.sv
// Places NUM_MINES distinct mines from an LFSR, then fills the
// per-cell adjacency file; cells are read back through a registered port.
module mine_placer
    import minesweeper_pkg::*;
#(
    parameter int                NUM_MINES = 4,
    parameter logic [LFSR_W-1:0] SEED      = 8'hA5
) (
    input  logic          clka,
    input  logic          restart_n,
    mine_placer_if.slave  bus
);

    if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_mines
        $error("mine_placer: NUM_MINES out of range 1..CELLS-1");
    end

    localparam logic [IDX_W-1:0] LAST   = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] TARGET = IDX_W'(NUM_MINES);

    place_state_e state_q, state_d;

    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  cand;
    logic              cand_ok;
    logic              unused_lfsr;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CELLS-1:0]  map_q, map_d;
    logic [ADJ_W-1:0]  adj_q [CELLS];
    logic [ADJ_W-1:0]  nsum;
    logic              adj_we, adj_clr;

    logic              done_q, busy_q;
    logic              rd_ok;
    logic              rd_mine_q;
    logic [ADJ_W-1:0]  rd_adj_q;

    mine_lfsr #(.SEED(SEED)) u_lfsr (
        .clka      (clka),
        .restart_n (restart_n),
        .step_i    (1'b1),
        .lfsr_o    (lfsr)
    );

    assign cand        = lfsr[IDX_W-1:0];
    assign unused_lfsr = ^lfsr[LFSR_W-1:IDX_W];
    assign cand_ok     = (int'(cand) < CELLS) && !map_q[cand];
    assign cnt_inc     = cnt_q + 1'b1;

    // Neighbour count of idx_q, clipped at the board edges (no wrap).
    always_comb begin
        int r;
        int c;
        r    = 0;
        c    = 0;
        nsum = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = idx_row(idx_q) + dr;
                c = idx_col(idx_q) + dc;
                if ((dr != 0 || dc != 0) && in_board(r, c)) begin
                    nsum = nsum +
                        ADJ_W'(map_q[IDX_W'(r * BOARD_W + c)]);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        map_d   = map_q;
        adj_we  = 1'b0;
        adj_clr = 1'b0;
        unique case (state_q)
            IDLE: ;
            CLEAR: begin
                map_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                adj_clr = 1'b1;
                state_d = PICK;
            end
            PICK: begin
                if (cand_ok) begin
                    map_d[cand] = 1'b1;
                    cnt_d       = cnt_inc;
                    if (cnt_inc == TARGET) begin
                        idx_d   = '0;
                        state_d = ADJ;
                    end
                end
            end
            ADJ: begin
                adj_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        if (bus.start) state_d = CLEAR;
    end

    always_ff @(posedge clka) begin
        if (!restart_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            map_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            map_q  <= map_d;
            done_q <= (state_d == DONE);
            busy_q <= (state_d == CLEAR) ||
                      (state_d == PICK)  ||
                      (state_d == ADJ);
        end
    end

    always_ff @(posedge clka) begin
        if (!restart_n || adj_clr) begin
            for (int i = 0; i < CELLS; i++) adj_q[i] <= '0;
        end else if (adj_we) begin
            adj_q[idx_q] <= nsum;
        end
    end

    assign rd_ok = int'(bus.rd_addr) < CELLS;

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            rd_mine_q <= 1'b0;
            rd_adj_q  <= '0;
        end else begin
            rd_mine_q <= rd_ok && map_q[bus.rd_addr];
            rd_adj_q  <= rd_ok ? adj_q[bus.rd_addr] : '0;
        end
    end

    assign bus.place_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.mine_map   = map_q;
    assign bus.rd_mine    = rd_mine_q;
    assign bus.rd_adj     = rd_adj_q;

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: a 4-mine and a 24-mine instance
// share clock and reset; read-port results are checked by a monitor.
module tb_mine_placer;

    logic clk;
    logic rst_n;

    logic [1:0]       start;
    logic [1:0][4:0]  addr;
    logic [1:0]       done_w;
    logic [1:0]       busy_w;
    logic [1:0][24:0] map_w;
    logic [1:0]       rd_mine_w;
    logic [1:0][3:0]  rd_adj_w;

    mine_placer_if b0 ();
    mine_placer_if b1 ();

    mine_placer #(.NUM_MINES(4), .SEED(8'hA5)) dut (
        .clka      (clk),
        .restart_n (rst_n),
        .bus       (b0.slave)
    );

    mine_placer #(.NUM_MINES(24), .SEED(8'hA5)) dut24 (
        .clka      (clk),
        .restart_n (rst_n),
        .bus       (b1.slave)
    );

    assign b0.start   = start[0];
    assign b1.start   = start[1];
    assign b0.rd_addr = addr[0];
    assign b1.rd_addr = addr[1];

    assign done_w    = {b1.place_done, b0.place_done};
    assign busy_w    = {b1.busy, b0.busy};
    assign map_w[0]  = b0.mine_map;
    assign map_w[1]  = b1.mine_map;
    assign rd_mine_w = {b1.rd_mine, b0.rd_mine};
    assign rd_adj_w[0] = b0.rd_adj;
    assign rd_adj_w[1] = b1.rd_adj;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [4:0] addr;
        logic       m;
        logic [3:0] a;
    } rd_item_t;

    rd_item_t sb[$];
    logic     rd_issue;
    int       n_vec;
    int       n_bad;
    logic [24:0] m_first;
    logic [24:0] m_cur;
    int       cyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] gold_adj(input logic [24:0] m,
                                            input int a);
        int r;
        int c;
        int n;
        r = a / 5;
        c = a % 5;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) &&
                    r + dr >= 0 && r + dr < 5 &&
                    c + dc >= 0 && c + dc < 5)
                    n += int'(m[(r + dr) * 5 + (c + dc)]);
        return n[3:0];
    endfunction

    // Monitor: the read issued before this edge is visible 1 time unit later.
    always @(posedge clk) begin : mon
        rd_item_t it;
        logic     v;
        v = rd_issue;
        #1;
        if (v) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow: got empty queue, expected item");
            end else begin
                it = sb.pop_front();
                chk($sformatf("rd_mine[%0d].%0d", it.inst, it.addr),
                    32'(rd_mine_w[it.inst]), 32'(it.m));
                chk($sformatf("rd_adj[%0d].%0d", it.inst, it.addr),
                    32'(rd_adj_w[it.inst]), 32'(it.a));
            end
        end
    end

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int c0);
        cyc = c0;
        while (!done_w[k] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("done_lat[%0d] cyc=%0d", k, cyc),
            32'(done_w[k] && cyc <= 282), 32'd1);
    endtask

    task automatic sweep(input int k, input logic [24:0] m);
        logic [4:0] a;
        for (int i = 0; i < 27; i++) begin
            a = (i < 25) ? 5'(i) : ((i == 25) ? 5'd25 : 5'd31);
            addr[k]  = a;
            rd_issue = 1'b1;
            sb.push_back('{inst: k, addr: a,
                           m: (i < 25) ? m[i] : 1'b0,
                           a: (i < 25) ? gold_adj(m, i) : 4'd0});
            @(negedge clk);
        end
        rd_issue = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = '0;
        addr     = '0;
        rd_issue = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_map", 32'(map_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_rd_adj", 32'(rd_adj_w[0]), 32'd0);
        chk("rst_rd_mine", 32'(rd_mine_w[0]), 32'd0);
        chk("rst_lfsr", 32'(dut.u_lfsr.lfsr_o), 32'hA5);
        chk("rst_busy24", 32'(busy_w[1]), 32'd0);
        rst_n = 1'b1;

        // First game, start 10 cycles after release.
        repeat (10) @(negedge clk);
        pulse_start(0);
        chk("busy_after_start", 32'(busy_w[0]), 32'd1);
        chk("done_after_start", 32'(done_w[0]), 32'd0);
        wait_done(0, 1);
        chk("busy_in_done", 32'(busy_w[0]), 32'd0);
        chk("popcount", $countones(map_w[0]), 32'd4);
        m_first = map_w[0];
        sweep(0, m_first);

        // Same timing after a fresh reset must reproduce the board.
        do_reset();
        repeat (10) @(negedge clk);
        pulse_start(0);
        wait_done(0, 1);
        chk("determinism", 32'(map_w[0]), 32'(m_first));

        // Reset in the middle of PICK.
        pulse_start(0);
        @(negedge clk);
        @(negedge clk);
        chk("pick_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midpick_map", 32'(map_w[0]), 32'd0);
        chk("midpick_busy", 32'(busy_w[0]), 32'd0);
        chk("midpick_done", 32'(done_w[0]), 32'd0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_done(0, 1);
        chk("popcount_after_rst", $countones(map_w[0]), 32'd4);
        m_cur = map_w[0];
        sweep(0, m_cur);

        // start while DONE.
        pulse_start(0);
        chk("restart_done_low", 32'(done_w[0]), 32'd0);
        chk("restart_busy", 32'(busy_w[0]), 32'd1);
        wait_done(0, 1);
        chk("popcount_restart", $countones(map_w[0]), 32'd4);
        m_cur = map_w[0];
        sweep(0, m_cur);

        // start during ADJ.
        pulse_start(0);
        cyc = 0;
        while ($countones(map_w[0]) != 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_adj", 32'(cyc < 300), 32'd1);
        repeat (5) @(negedge clk);
        chk("in_adj_done", 32'(done_w[0]), 32'd0);
        pulse_start(0);
        chk("adj_restart_busy", 32'(busy_w[0]), 32'd1);
        @(negedge clk);
        chk("adj_restart_clear", 32'(map_w[0]), 32'd0);
        wait_done(0, 2);
        chk("popcount_adj_restart", $countones(map_w[0]), 32'd4);
        m_cur = map_w[0];
        sweep(0, m_cur);

        // 24-mine instance: exactly one clear cell.
        pulse_start(1);
        chk("busy24", 32'(busy_w[1]), 32'd1);
        wait_done(1, 1);
        chk("popcount24", $countones(map_w[1]), 32'd24);
        m_cur = map_w[1];
        sweep(1, m_cur);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
